// File: rtl/ex_wb_stage.sv
// Pipeline back end: MEM and WB stages, data-memory write handshake, register-file
// write port, EX-side forwarding and a saturating retired-instruction counter.
module ex_wb_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_wreg_en,
    input  logic              ex_wmem_en,
    input  logic [DATA_W-1:0] ex_r1out,
    input  logic [DATA_W-1:0] ex_r2out,
    input  logic [4:0]        ex_wreg1,
    output logic              stall_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [0:0] {MIdle, MWait} mem_state_e;

    mem_state_e state_q, state_d;

    logic              mem_valid_q, mem_wreg_en_q, mem_wmem_en_q;
    logic [DATA_W-1:0] mem_r1_q, mem_r2_q;
    logic [4:0]        mem_wreg_q;

    logic              wb_valid_q, wb_wreg_en_q;
    logic [DATA_W-1:0] wb_r1_q;
    logic [4:0]        wb_wreg_q;

    logic [CNT_W-1:0]  cnt_q;

    logic mem_fwd1, mem_fwd2, wb_fwd1, wb_fwd2;

    // Outputs come straight from the MEM register, so an async reset drops them at once.
    assign mem_we    = mem_valid_q & mem_wmem_en_q;
    assign stall_out = mem_we & ~mem_ready;
    assign mem_addr  = mem_r1_q[ADDR_W-1:0];
    assign mem_wdata = mem_r2_q;

    assign rf_we       = wb_valid_q & wb_wreg_en_q & (wb_wreg_q != 5'd0);
    assign rf_waddr    = wb_wreg_q;
    assign rf_wdata    = wb_r1_q;
    assign retired_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MIdle: if (mem_we && !mem_ready) state_d = MWait;
            MWait: if (mem_ready) state_d = MIdle;
            default: state_d = MIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid_q   <= 1'b0;
            mem_wreg_en_q <= 1'b0;
            mem_wmem_en_q <= 1'b0;
            mem_r1_q      <= '0;
            mem_r2_q      <= '0;
            mem_wreg_q    <= 5'd0;
        end else if (!stall_out) begin
            mem_valid_q   <= ex_valid;
            mem_wreg_en_q <= ex_wreg_en;
            mem_wmem_en_q <= ex_wmem_en;
            mem_r1_q      <= ex_r1out;
            mem_r2_q      <= ex_r2out;
            mem_wreg_q    <= ex_wreg1;
        end
    end

    // A stalled MEM entry must not reach WB twice; only the valid bit is cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q   <= 1'b0;
            wb_wreg_en_q <= 1'b0;
            wb_r1_q      <= '0;
            wb_wreg_q    <= 5'd0;
        end else if (stall_out) begin
            wb_valid_q   <= 1'b0;
        end else begin
            wb_valid_q   <= mem_valid_q;
            wb_wreg_en_q <= mem_wreg_en_q;
            wb_r1_q      <= mem_r1_q;
            wb_wreg_q    <= mem_wreg_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (wb_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_fwd1 = mem_valid_q & mem_wreg_en_q & (mem_wreg_q != 5'd0) & (mem_wreg_q == id_rs1);
        mem_fwd2 = mem_valid_q & mem_wreg_en_q & (mem_wreg_q != 5'd0) & (mem_wreg_q == id_rs2);
        wb_fwd1  = wb_valid_q & wb_wreg_en_q & (wb_wreg_q != 5'd0) & (wb_wreg_q == id_rs1);
        wb_fwd2  = wb_valid_q & wb_wreg_en_q & (wb_wreg_q != 5'd0) & (wb_wreg_q == id_rs2);

        fwd_hit1  = mem_fwd1 | wb_fwd1;
        fwd_hit2  = mem_fwd2 | wb_fwd2;
        fwd_data1 = '0;
        fwd_data2 = '0;
        if (mem_fwd1) begin
            fwd_data1 = mem_r1_q;
        end else if (wb_fwd1) begin
            fwd_data1 = wb_r1_q;
        end
        if (mem_fwd2) begin
            fwd_data2 = mem_r1_q;
        end else if (wb_fwd2) begin
            fwd_data2 = wb_r1_q;
        end
    end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Back end of the pipeline, downstream of the ID/EX register. Captures the EX-stage bundle (write enables, two 64-bit operands, destination register) into a MEM stage and a WB stage. Issues data-memory writes with a ready handshake, drives the register-file write port, and returns forwarding data plus a stall to the ID/EX side. Also keeps a saturating count of retired instructions.

## Interface
Parameters:
- DATA_W, 64, operand and write-data width
- ADDR_W, 8, data-memory address width; taken from low bits of R1out
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- ex_valid  in  1  EX bundle holds a real instruction
- ex_wreg_en  in  1  instruction writes the register file
- ex_wmem_en  in  1  instruction writes data memory
- ex_r1out  in  DATA_W  register write data; memory address source
- ex_r2out  in  DATA_W  memory write data
- ex_wreg1  in  5  destination register
- stall_out  out  1  upstream must hold its EX bundle this cycle
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  memory write address = r1out[ADDR_W-1:0]
- mem_wdata  out  DATA_W  memory write data = r2out
- mem_ready  in  1  memory accepts the request this cycle
- rf_we  out  1  register-file write strobe
- rf_waddr  out  5  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- fwd_hit1, fwd_hit2  out  1 each  forwarding valid for rs1/rs2
- fwd_data1, fwd_data2  out  DATA_W each  forwarded value
- retired_cnt  out  CNT_W  instructions retired from WB, saturating

## Operation
- MEM register: {valid, wreg_en, wmem_en, r1, r2, wreg}. It loads from ex_* on a clock edge when stall_out=0.
- WB register: {valid, wreg_en, r1, wreg}. It loads from MEM when stall_out=0. It loads a bubble (valid=0) when stall_out=1.
- Memory handshake FSM:
  - States: M_IDLE and M_WAIT.
  - mem_we = mem_valid & mem_wmem_en. It is combinational from the MEM register in both states.
  - M_IDLE to M_WAIT: mem_we=1 and mem_ready=0.
  - M_WAIT to M_IDLE: mem_ready=1.
  - stall_out = mem_we & ~mem_ready.
  - mem_addr and mem_wdata are held stable while stalled.
- Register write:
  - rf_we = wb_valid & wb_wreg_en & (wb_wreg != 0).
  - rf_waddr = wb_wreg; rf_wdata = wb_r1.
  - Writes to r0 are dropped.
- An instruction with both enables set does its memory write in MEM, then its register write in WB.
- Forwarding, per source port:
  - A candidate stage must be valid, have wreg_en=1, have wreg equal to the source register, and have wreg != 0.
  - MEM has priority over WB.
  - fwd_data = r1 of the winning stage; hit=0 if neither stage matches.
  - fwd_data is 0 when hit=0.
- retired_cnt increments on each edge where wb_valid=1. It saturates at all-ones.
- ex_* values are ignored while stall_out=1; the upstream stage holds them.

## Timing
- Reset: all valid bits, state registers and outputs are 0. This covers mem_we, rf_we, stall_out, fwd_hit*, fwd_data*, retired_cnt, and FSM state M_IDLE.
- Reset takes effect immediately and is asynchronous. A reset during M_WAIT drops the pending write; mem_we deasserts without waiting for the clock.
- Latency: an EX bundle captured at edge N appears on mem_* in cycle N to N+1. With no stall, it appears on rf_* in cycle N+1 to N+2.
- Each cycle stall_out=1 adds one cycle to both stages and inserts one WB bubble.
- The handshake completes in the cycle where mem_we & mem_ready are both high. The MEM entry advances at the next edge.
- Simultaneous events:
  - If MEM and WB both match id_rs1, the data comes from MEM.
  - If a register-file write and an ID read of the same register occur in the same cycle, the value is also forwarded from WB. The register file needs no write-through.
- Counter: retired_cnt updates at the edge that retires the WB entry. At saturation it holds its value.

## Test plan
- Reset mid-stream: load three valid bundles, then pull reset low between edges. The bench must see mem_we, rf_we, stall_out and retired_cnt drop to 0 immediately.
- Register write: ex_valid=1, wreg_en=1, wreg1=5, r1out=0x1234 at edge 0. Expected: rf_we=1, rf_waddr=5, rf_wdata=0x1234 after edge 1; retired_cnt=1 after edge 2. Repeating with wreg1=0 must give rf_we=0 while retired_cnt still increments.
- Memory stall: wmem_en=1, r1out=0x1FF, r2out=0xABCD, with mem_ready held low for 3 cycles. Expected: mem_we=1, mem_addr=0xFF, mem_wdata=0xABCD and stall_out=1 for 3 cycles. WB must show 3 bubbles. The next instruction enters MEM one edge after mem_ready=1.
- Forwarding priority: write r7 with 0x11, then r7 with 0x22 on the next edge, with id_rs1=7. Expected: fwd_hit1=1 and fwd_data1=0x22 while the second bundle is in MEM, then 0x22 from WB. id_rs2=0 must always give fwd_hit2=0.
- Combined instruction: both enables set, wreg1=3, r1out=0x40, r2out=0x99, with mem_ready=1. Expected: the memory write with addr 0x40 and data 0x99 occurs one cycle before the register-file write of r3=0x40.
- Saturation: with CNT_W=4, retire 20 bundles. Expected: retired_cnt stops at 15.
